fetch_unit: RTL

- Instruction fetch stage sitting directly upstream of the single-cycle datapath.
- Owns the PC and drives the memory read handshake (readM / address / inputReady / data).
- Holds one fetched instruction in a buffer and hands it to the datapath with a valid/ready handshake.
- Accepts PC redirects (jump/branch) from the datapath, flushes stale fetches, and flags memory timeouts.

---
 rtl/fetch_unit.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage in front of the single-cycle datapath. Owns the PC,
// runs the memory read handshake, buffers one fetched instruction and hands it
// to the datapath with a valid/ready handshake. Accepts PC redirects, drops
// fetches made stale by a redirect, and flags memory that never answers.
//
// Ports:
//   clk          clock
//   reset_n      asynchronous active-low reset
//   readM        memory read request (high for the whole request)
//   address      memory read address, stable while readM=1
//   data         memory read data, valid when inputReady=1
//   inputReady   memory data-valid strobe, sampled on posedge clk
//   inst         buffered instruction
//   inst_pc      address the buffered instruction came from
//   inst_valid   buffer holds an instruction
//   inst_ready   datapath consumes inst this cycle
//   redirect     load redirect_pc into the PC and flush the buffer
//   redirect_pc  redirect target
//   fetch_err    sticky memory-timeout error (cleared only by redirect/reset)
//   num_fetch    count of instructions consumed by the datapath
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
  parameter int                   TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 readM,
  output logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  output logic [WORD_SIZE-1:0] inst,
  output logic [WORD_SIZE-1:0] inst_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 fetch_err,
  output logic [WORD_SIZE-1:0] num_fetch
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    NEXT,
    ERR
  } state_t;

  state_t               state, state_d;
  logic [WORD_SIZE-1:0] pc, pc_d;
  logic [WORD_SIZE-1:0] address_d;
  logic [WORD_SIZE-1:0] inst_d, inst_pc_d;
  logic                 inst_valid_d;
  logic                 fetch_err_d;
  logic [WORD_SIZE-1:0] num_fetch_d;
  logic [7:0]           wait_cnt, wait_cnt_d;
  logic                 discard, discard_d;
  logic                 buf_free;
  logic                 consume;

  // A request is outstanding exactly while in REQ; deriving readM from the
  // state makes an asynchronous reset drop it immediately.
  assign readM = (state == REQ);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d      = state;
    pc_d         = pc;
    address_d    = address;
    inst_d       = inst;
    inst_pc_d    = inst_pc;
    inst_valid_d = inst_valid;
    fetch_err_d  = fetch_err;
    num_fetch_d  = num_fetch;
    wait_cnt_d   = wait_cnt;
    discard_d    = discard;

    buf_free = !inst_valid || inst_ready;
    // A redirect flushes the buffer, so a coincident consume is not counted.
    consume  = inst_valid && inst_ready && !redirect;

    if (consume) begin
      num_fetch_d  = num_fetch + WORD_SIZE'(1);
      inst_valid_d = 1'b0;
    end

    unique case (state)
      IDLE: begin
        state_d    = REQ;
        address_d  = redirect ? redirect_pc : pc;
        wait_cnt_d = '0;
      end

      REQ: begin
        if (inputReady) begin
          state_d = NEXT;
          if (discard || redirect) begin
            // Stale data: the PC was redirected after this read was issued.
            discard_d = 1'b0;
          end else begin
            inst_d       = data;
            inst_pc_d    = address;
            inst_valid_d = 1'b1;
            pc_d         = address + WORD_SIZE'(1);
          end
        end else begin
          wait_cnt_d = wait_cnt + 8'd1;
          // The read in flight cannot be withdrawn; remember to drop its data.
          if (redirect) discard_d = 1'b1;
          if (wait_cnt_d == TIMEOUT_CNT) begin
            // The abandoned read will never be consumed, so nothing to discard.
            state_d     = ERR;
            fetch_err_d = 1'b1;
            discard_d   = 1'b0;
          end
        end
      end

      NEXT: begin
        if (redirect || buf_free) begin
          state_d    = REQ;
          address_d  = redirect ? redirect_pc : pc;
          wait_cnt_d = '0;
        end
      end

      ERR: begin
        if (redirect) begin
          state_d     = REQ;
          address_d   = redirect_pc;
          wait_cnt_d  = '0;
          fetch_err_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase

    // Redirect overrides any PC update and empties the buffer.
    if (redirect) begin
      pc_d         = redirect_pc;
      inst_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      address    <= RESET_PC;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      fetch_err  <= 1'b0;
      num_fetch  <= '0;
      wait_cnt   <= '0;
      discard    <= 1'b0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      address    <= address_d;
      inst       <= inst_d;
      inst_pc    <= inst_pc_d;
      inst_valid <= inst_valid_d;
      fetch_err  <= fetch_err_d;
      num_fetch  <= num_fetch_d;
      wait_cnt   <= wait_cnt_d;
      discard    <= discard_d;
    end
  end

endmodule
